mdio_responder: RTL and testbench

//  Clause-22 MDIO target (PHY-side management responder), the far end of the
//  PHY_MDIO/PHY_MDC master inside network. Used for PHY-less loopback builds and

---
 rtl/mdio_responder_if.sv | 22 ++
 rtl/mdio_responder.sv | 244 ++++++++++++++++++++++++
 tb/tb_mdio_responder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mdio_responder_if.sv
// MDIO responder bus: pad-side MDC/MDIO, link status input and write-report outputs.
interface mdio_responder_if;
    logic        mdc;
    logic        mdio_i;
    logic        mdio_o;
    logic        mdio_oe;
    logic        link_up;
    logic        wr_strobe;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        soft_reset;

    modport master (
        output mdc, mdio_i, link_up,
        input  mdio_o, mdio_oe, wr_strobe, wr_addr, wr_data, soft_reset
    );

    modport slave (
        input  mdc, mdio_i, link_up,
        output mdio_o, mdio_oe, wr_strobe, wr_addr, wr_data, soft_reset
    );
endinterface

// File: rtl/mdio_responder.sv
// Clause-22 MDIO target: oversamples MDC/MDIO, decodes frames, serves a 32x16
// register file (reg0 control, reg1 status, reg2/3 PHY ID, reg4..31 scratch).
module mdio_responder #(
    parameter logic [4:0]  PHY_ADDR       = 5'd1,
    parameter int unsigned PREAMBLE_MIN   = 32,
    parameter logic [31:0] PHY_ID         = 32'h0007C0F1,
    parameter logic [15:0] REG0_DEFAULT   = 16'h3100,
    parameter logic [15:0] STATUS_BASE    = 16'h7809,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    mdio_responder_if.slave  bus
);

    localparam int unsigned PC_W = $clog2(PREAMBLE_MIN + 1);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [PC_W-1:0] PRE_MAX = PC_W'(PREAMBLE_MIN);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ST    = 3'd1;
    localparam logic [2:0] S_OP    = 3'd2;
    localparam logic [2:0] S_PHYAD = 3'd3;
    localparam logic [2:0] S_REGAD = 3'd4;
    localparam logic [2:0] S_TA    = 3'd5;
    localparam logic [2:0] S_DATA  = 3'd6;

    logic [2:0]      mdc_s;
    logic [1:0]      mdio_s;
    logic            mdc_rise;
    logic            bit_in;

    logic [2:0]      state;
    logic [PC_W-1:0] pre_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [3:0]      bit_cnt;
    logic            op_hi;
    logic            is_read;
    logic            addr_match;
    logic [4:0]      phyad;
    logic [4:0]      regad;
    logic [15:0]     shift;

    logic            mdio_o_q;
    logic            mdio_oe_q;
    logic            wr_strobe_q;
    logic [4:0]      wr_addr_q;
    logic [15:0]     wr_data_q;
    logic            soft_reset_q;

    logic [15:0]     reg0;
    logic [15:0]     gp_regs [4:31];

    logic [4:0]      regad_nx;
    logic [15:0]     wdata_nx;
    logic [15:0]     rd_value;
    logic            rd_act;

    assign mdc_rise = mdc_s[1] & ~mdc_s[2];
    assign bit_in   = mdio_s[1];
    assign regad_nx = {regad[3:0], bit_in};
    assign wdata_nx = {shift[14:0], bit_in};
    assign rd_act   = is_read & addr_match;

    assign bus.mdio_o     = mdio_o_q;
    assign bus.mdio_oe    = mdio_oe_q;
    assign bus.wr_strobe  = wr_strobe_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.soft_reset = soft_reset_q;

    // Two-stage synchronisers for MDC and MDIO, plus one MDC history bit for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdc_s  <= '0;
            mdio_s <= '0;
        end else begin
            mdc_s  <= {mdc_s[1:0], bus.mdc};
            mdio_s <= {mdio_s[0], bus.mdio_i};
        end
    end

    // Read value for the register addressed by the REGAD bit arriving now (snapshot at E0)
    always_comb begin
        rd_value = '0;
        case (regad_nx)
            5'd0: rd_value = reg0 & 16'h7FFF;
            5'd1: begin
                rd_value    = STATUS_BASE;
                rd_value[2] = bus.link_up;
            end
            5'd2: rd_value = PHY_ID[31:16];
            5'd3: rd_value = PHY_ID[15:0];
            default: rd_value = gp_regs[regad_nx];
        endcase
    end

    // Frame decoder, turnaround/data shifter, write commit and timeout abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            pre_cnt      <= '0;
            to_cnt       <= '0;
            bit_cnt      <= '0;
            op_hi        <= 1'b0;
            is_read      <= 1'b0;
            addr_match   <= 1'b0;
            phyad        <= '0;
            regad        <= '0;
            shift        <= '0;
            mdio_o_q     <= 1'b0;
            mdio_oe_q    <= 1'b0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            soft_reset_q <= 1'b0;
            reg0         <= REG0_DEFAULT;
            for (int unsigned i = 4; i < 32; i++) begin
                gp_regs[i] <= '0;
            end
        end else begin
            wr_strobe_q  <= 1'b0;
            soft_reset_q <= 1'b0;

            // Abort only fires on a cycle without a rise, so it never collides with the decoder below
            if (state == S_IDLE || mdc_rise) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
                to_cnt    <= '0;
                state     <= S_IDLE;
                pre_cnt   <= '0;
                mdio_oe_q <= 1'b0;
                mdio_o_q  <= 1'b0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (mdc_rise) begin
                case (state)
                    S_IDLE: begin
                        if (bit_in) begin
                            if (pre_cnt < PRE_MAX) pre_cnt <= pre_cnt + 1'b1;
                        end else if (pre_cnt == PRE_MAX) begin
                            state   <= S_ST;
                            pre_cnt <= '0;
                        end else begin
                            pre_cnt <= '0;
                        end
                    end
                    S_ST: begin
                        bit_cnt <= '0;
                        state   <= bit_in ? S_OP : S_IDLE;
                    end
                    S_OP: begin
                        if (bit_cnt == 4'd0) begin
                            op_hi   <= bit_in;
                            bit_cnt <= 4'd1;
                        end else if (op_hi != bit_in) begin
                            is_read <= op_hi;
                            bit_cnt <= '0;
                            state   <= S_PHYAD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_PHYAD: begin
                        phyad <= {phyad[3:0], bit_in};
                        if (bit_cnt == 4'd4) begin
                            bit_cnt <= '0;
                            state   <= S_REGAD;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    S_REGAD: begin
                        regad <= regad_nx;
                        if (bit_cnt == 4'd4) begin
                            bit_cnt    <= '0;
                            state      <= S_TA;
                            addr_match <= (phyad == PHY_ADDR);
                            if (is_read && phyad == PHY_ADDR) shift <= rd_value;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    S_TA: begin
                        if (bit_cnt == 4'd0) begin
                            bit_cnt <= 4'd1;
                            if (rd_act) begin
                                mdio_oe_q <= 1'b1;
                                mdio_o_q  <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= '0;
                            state   <= S_DATA;
                            if (rd_act) begin
                                mdio_o_q <= shift[15];
                                shift    <= {shift[14:0], 1'b0};
                            end
                        end
                    end
                    S_DATA: begin
                        // D15 went out at E2, so the last DATA edge releases the line instead of shifting
                        if (rd_act) begin
                            if (bit_cnt == 4'd15) begin
                                mdio_oe_q <= 1'b0;
                                mdio_o_q  <= 1'b0;
                            end else begin
                                mdio_o_q <= shift[15];
                                shift    <= {shift[14:0], 1'b0};
                            end
                        end else begin
                            shift <= wdata_nx;
                        end
                        if (bit_cnt == 4'd15) begin
                            state   <= S_IDLE;
                            pre_cnt <= '0;
                            if (!is_read && addr_match) begin
                                wr_strobe_q <= 1'b1;
                                wr_addr_q   <= regad;
                                wr_data_q   <= wdata_nx;
                                if (regad == 5'd0) begin
                                    if (wdata_nx[15]) begin
                                        reg0         <= REG0_DEFAULT;
                                        soft_reset_q <= 1'b1;
                                    end else begin
                                        reg0 <= wdata_nx;
                                    end
                                end else if (regad >= 5'd4) begin
                                    gp_regs[regad] <= wdata_nx;
                                end
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: drives MDC/MDIO frames, checks reads, writes and aborts.
module tb_mdio_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdio_responder_if bus ();

    mdio_responder #(
        .PHY_ADDR       (5'd1),
        .PREAMBLE_MIN   (32),
        .PHY_ID         (32'h0007C0F1),
        .REG0_DEFAULT   (16'h3100),
        .STATUS_BASE    (16'h7809),
        .TIMEOUT_CYCLES (4096)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    int strobe_cnt = 0;
    int soft_cnt   = 0;
    int both_cnt   = 0;
    int oe_clks    = 0;

    logic obs_oe [0:18];
    logic obs_o  [0:18];

    // Event counters for strobes and line drive
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.wr_strobe) strobe_cnt++;
            if (bus.soft_reset) soft_cnt++;
            if (bus.wr_strobe && bus.soft_reset) both_cnt++;
            if (bus.mdio_oe) oe_clks++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clock_bit(input logic b);
        @(negedge clk);
        bus.mdio_i = b;
        repeat (3) @(negedge clk);
        bus.mdc = 1'b1;
        repeat (4) @(negedge clk);
        bus.mdc = 1'b0;
    endtask

    // op: 2'b10 read, 2'b01 write; stop_edge < 0 runs the full frame
    task automatic frame(input int pre_len, input logic [1:0] op, input logic [4:0] phy,
                         input logic [4:0] ra, input logic [15:0] wd, input int stop_edge,
                         output logic [15:0] rd);
        logic [13:0] hdr;
        logic b;
        hdr = {2'b01, op, phy, ra};
        rd = '0;
        for (int i = 0; i < pre_len; i++) clock_bit(1'b1);
        for (int i = 13; i >= 0; i--) clock_bit(hdr[i]);
        obs_oe[0] = bus.mdio_oe;
        obs_o[0]  = bus.mdio_o;
        for (int e = 1; e <= 18; e++) begin
            if (stop_edge >= 0 && e > stop_edge) break;
            if (op == 2'b01) b = (e == 1) ? 1'b1 : (e == 2) ? 1'b0 : wd[18-e];
            else b = 1'b1;
            clock_bit(b);
            obs_oe[e] = bus.mdio_oe;
            obs_o[e]  = bus.mdio_o;
            if (e >= 2 && e <= 17) rd[17-e] = bus.mdio_o;
        end
        bus.mdio_i = 1'b1;
    endtask

    logic [15:0] rd;
    logic        oe_all;
    int          s0, sf0, b0, o0;

    initial begin
        bus.mdc     = 1'b0;
        bus.mdio_i  = 1'b1;
        bus.link_up = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_oe", 32'(bus.mdio_oe), 32'd0);
        check("rst_o", 32'(bus.mdio_o), 32'd0);
        check("rst_strobe", 32'({bus.wr_strobe, bus.soft_reset}), 32'd0);
        check("rst_wr", 32'({bus.wr_addr, bus.wr_data}), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Read PHY ID high word
        frame(32, 2'b10, 5'd1, 5'd2, 16'h0, -1, rd);
        check("t1_oe_e0", 32'(obs_oe[0]), 32'd0);
        check("t1_ta_oe", 32'(obs_oe[1]), 32'd1);
        check("t1_ta_o", 32'(obs_o[1]), 32'd0);
        oe_all = 1'b1;
        for (int e = 2; e <= 17; e++) oe_all &= obs_oe[e];
        check("t1_oe_data", 32'(oe_all), 32'd1);
        check("t1_data", 32'(rd), 32'h0007);
        check("t1_oe_e18", 32'(obs_oe[18]), 32'd0);

        // Write scratch reg4 then read back
        s0 = strobe_cnt; o0 = oe_clks;
        frame(32, 2'b01, 5'd1, 5'd4, 16'hA5C3, -1, rd);
        check("t2_strobes", 32'(strobe_cnt - s0), 32'd1);
        check("t2_addr", 32'(bus.wr_addr), 32'd4);
        check("t2_data", 32'(bus.wr_data), 32'hA5C3);
        check("t2_no_drive", 32'(oe_clks - o0), 32'd0);
        frame(32, 2'b10, 5'd1, 5'd4, 16'h0, -1, rd);
        check("t2_readback", 32'(rd), 32'hA5C3);

        // Foreign PHYAD: no drive, no write
        o0 = oe_clks;
        frame(32, 2'b10, 5'd5, 5'd2, 16'h0, -1, rd);
        check("t3_rd_no_oe", 32'(oe_clks - o0), 32'd0);
        s0 = strobe_cnt;
        frame(32, 2'b01, 5'd5, 5'd4, 16'h1234, -1, rd);
        check("t3_wr_no_strobe", 32'(strobe_cnt - s0), 32'd0);
        frame(32, 2'b10, 5'd1, 5'd4, 16'h0, -1, rd);
        check("t3_reg4_kept", 32'(rd), 32'hA5C3);

        // Short preamble and illegal opcode are ignored
        o0 = oe_clks; s0 = strobe_cnt;
        frame(31, 2'b10, 5'd1, 5'd2, 16'h0, -1, rd);
        check("t4_short_pre", 32'(oe_clks - o0), 32'd0);
        frame(32, 2'b11, 5'd1, 5'd4, 16'h0, -1, rd);
        check("t4_op11_oe", 32'(oe_clks - o0), 32'd0);
        check("t4_op11_strobe", 32'(strobe_cnt - s0), 32'd0);
        frame(32, 2'b10, 5'd1, 5'd3, 16'h0, -1, rd);
        check("t4_after_idle", 32'(rd), 32'hC0F1);

        // Status register tracks link_up
        bus.link_up = 1'b1;
        frame(32, 2'b10, 5'd1, 5'd1, 16'h0, -1, rd);
        check("reg1_link_up", 32'(rd), 32'h780D);
        bus.link_up = 1'b0;
        frame(32, 2'b10, 5'd1, 5'd1, 16'h0, -1, rd);
        check("reg1_link_dn", 32'(rd), 32'h7809);

        // Write to read-only reg2 strobes but changes nothing
        s0 = strobe_cnt;
        frame(32, 2'b01, 5'd1, 5'd2, 16'hFFFF, -1, rd);
        check("ro_strobe", 32'(strobe_cnt - s0), 32'd1);
        check("ro_addr", 32'(bus.wr_addr), 32'd2);
        frame(32, 2'b10, 5'd1, 5'd2, 16'h0, -1, rd);
        check("ro_unchanged", 32'(rd), 32'h0007);

        // reg0 plain write, then soft reset
        frame(32, 2'b01, 5'd1, 5'd0, 16'h1140, -1, rd);
        frame(32, 2'b10, 5'd1, 5'd0, 16'h0, -1, rd);
        check("reg0_write", 32'(rd), 32'h1140);
        sf0 = soft_cnt; b0 = both_cnt;
        frame(32, 2'b01, 5'd1, 5'd0, 16'h8000, -1, rd);
        check("t5_soft", 32'(soft_cnt - sf0), 32'd1);
        check("t5_same_clk", 32'(both_cnt - b0), 32'd1);
        check("t5_wr_data", 32'(bus.wr_data), 32'h8000);
        frame(32, 2'b10, 5'd1, 5'd0, 16'h0, -1, rd);
        check("t5_reg0_default", 32'(rd), 32'h3100);

        // MDC stall mid-read: driver held until timeout, then released
        frame(32, 2'b10, 5'd1, 5'd3, 16'h0, 8, rd);
        check("t6_oe_at_e8", 32'(bus.mdio_oe), 32'd1);
        repeat (4000) @(negedge clk);
        check("t6_oe_before_to", 32'(bus.mdio_oe), 32'd1);
        repeat (200) @(negedge clk);
        check("t6_oe_after_to", 32'(bus.mdio_oe), 32'd0);
        frame(32, 2'b10, 5'd1, 5'd3, 16'h0, -1, rd);
        check("t6_after_to_read", 32'(rd), 32'hC0F1);

        // Reset mid-read releases the line at once and restores defaults
        frame(32, 2'b10, 5'd1, 5'd4, 16'h0, 5, rd);
        check("t6_oe_at_e5", 32'(bus.mdio_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_release", 32'(bus.mdio_oe), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        frame(32, 2'b10, 5'd1, 5'd4, 16'h0, -1, rd);
        check("t6_reg4_cleared", 32'(rd), 32'h0000);
        frame(32, 2'b10, 5'd1, 5'd0, 16'h0, -1, rd);
        check("t6_reg0_after_rst", 32'(rd), 32'h3100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
